// File: rtl/icache_rd_bridge_pkg.sv
// Shared constants and types for the icache read bridge: AXI encodings,
// FSM state codes and the skid FIFO entry layout.
package icache_rd_bridge_pkg;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AR   = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam int FIFO_DEPTH = 2;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } ret_beat_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/icache_rd_bridge_if.sv
// AXI4 read address/data channels between the bridge (master) and the
// read arbiter (slave).
interface icache_rd_bridge_if #(
   parameter int ID_WIDTH = 4
);
   logic [ID_WIDTH-1:0] arid;
   logic [31:0]         araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [ID_WIDTH-1:0] rid;
   logic [31:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/icache_rd_bridge_rd_skid_fifo.sv
// Two-entry skid FIFO holding returned beats ({data, last}) for the cache.
// Push and pop in the same cycle are both honoured.
module rd_skid_fifo
   import icache_rd_bridge_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  ret_beat_t  din,
   input  logic       pop,
   output ret_beat_t  dout,
   output logic [1:0] count
);

   ret_beat_t mem [FIFO_DEPTH];
   logic      wr_ptr;
   logic      rd_ptr;
   logic      push_ok;
   logic      pop_ok;

   assign push_ok = push && (count != 2'd2);
   assign pop_ok  = pop && (count != 2'd0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: the storage is reset as well so the cache sees clean zero data after reset; at two entries this costs nothing.
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/icache_rd_bridge.sv
// Instruction-cache read responder: one cache request becomes one AXI4 INCR
// read burst; R beats return to the cache through a 2-entry skid FIFO.
module icache_rd_bridge
   import icache_rd_bridge_pkg::*;
#(
   parameter int ID_WIDTH = 4,
   parameter int AXI_ID   = 0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                r_req,
   input  logic [31:0]         r_addr,
   input  logic [7:0]          r_length,
   output logic                r_rdy,
   output logic                ret_valid,
   output logic                ret_last,
   output logic [31:0]         ret_data,
   input  logic                r_data_ready,
   output logic                rd_err,
   icache_rd_bridge_if.master  axi
);

   logic [1:0]  state;
   logic [31:0] araddr_q;
   logic [7:0]  arlen_q;
   logic [7:0]  beat_cnt;
   logic        all_pushed;
   logic        rd_err_q;

   logic        arvalid;
   logic        rready;
   logic        push;
   logic        pop;
   logic [1:0]  fifo_count;
   ret_beat_t   push_beat;
   ret_beat_t   head;
   logic        unused_inputs;

   // Single outstanding burst: rid and rlast carry no extra information.
   assign unused_inputs = ^{axi.rid, axi.rlast};

   assign arvalid     = (state == ST_AR);
   assign axi.arvalid = arvalid;
   assign axi.arid    = ID_WIDTH'(AXI_ID);
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign r_rdy       = arvalid & axi.arready;

   // Ready is taken from the pre-pop count so rvalid never sees a path
   // through r_data_ready.
   assign rready     = (state == ST_DATA) && !all_pushed && (fifo_count < 2'd2);
   assign axi.rready = rready;
   assign push       = axi.rvalid & rready;

   // Framing comes from the beat counter, never from rlast.
   assign push_beat.data = axi.rdata;
   assign push_beat.last = (beat_cnt == arlen_q);

   assign ret_valid = (fifo_count != 2'd0);
   assign ret_data  = head.data;
   assign ret_last  = ret_valid & head.last;
   assign pop       = ret_valid & r_data_ready;
   assign rd_err    = rd_err_q;

   rd_skid_fifo u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (push_beat),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: all state updates here are non-blocking so every register sees pre-edge values regardless of statement order.
         state      <= ST_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         beat_cnt   <= '0;
         all_pushed <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (r_req) begin
                  araddr_q   <= r_addr;
                  arlen_q    <= r_length;
                  beat_cnt   <= '0;
                  all_pushed <= 1'b0;
                  rd_err_q   <= 1'b0;
                  state      <= ST_AR;
               end
            end
            ST_AR: begin
               if (axi.arready) begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (push) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (push_beat.last) begin
                     all_pushed <= 1'b1;
                  end
                  if (resp_is_err(axi.rresp)) begin
                     rd_err_q <= 1'b1;
                  end
               end
               if (pop && head.last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
